mem_arbiter: RTL and testbench

- Shares one single-ported memory interface between the core's instruction fetch port (ibus) and data access port (dbus).
- Sits between the pipeline core and the memory or bus bridge.
- Latches the winning request, runs a two-phase (accept, then response) transaction downstream, and returns data_ok/data to the granted requester only.
- Round-robin on contention; otherwise serves whichever port is valid.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter_rr_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types and constants for the ibus/dbus memory arbiter.
//   arb_state_t : transaction FSM states (IDLE, REQ, WAIT)
//   arb_port_t  : which core port owns the current transaction
//   arb_req_t   : latched downstream request (addr, size, strobe, wdata)
//   MSIZE*      : access size encoding shared with the core's memory stage
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W  = 64;
  localparam int ARB_DATA_W  = 64;
  localparam int ARB_INSTR_W = 32;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    IBUS,
    DBUS
  } arb_port_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0]   addr;
    logic [2:0]              size;
    logic [ARB_DATA_W/8-1:0] strobe;
    logic [ARB_DATA_W-1:0]   wdata;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// arb_rr_pick
// Combinational two-way round-robin chooser.
//   i_valid, d_valid : pending requests from fetch and data ports
//   last_grant       : port that won the previous arbitration
//   grant            : port to serve now (meaningful only when any = 1)
//   any              : at least one request is pending
module arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic      i_valid,
  input  logic      d_valid,
  input  arb_port_t last_grant,
  output arb_port_t grant,
  output logic      any
);

  // On a tie the port that did not win last time gets its turn.
  always_comb begin
    any   = i_valid | d_valid;
    grant = IBUS;
    if (i_valid && d_valid) begin
      grant = (last_grant == DBUS) ? IBUS : DBUS;
    end else if (d_valid) begin
      grant = DBUS;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported memory interface between the instruction fetch
// port (ibus) and the data access port (dbus). A winning request is latched,
// issued downstream (accept phase), and its response is routed back to the
// owning port only (response phase).
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   i_valid/i_addr -> i_addr_ok      : fetch request / latched pulse
//   i_data_ok/i_data                 : fetch response pulse, selected word
//   d_valid/d_addr/d_size/d_strobe/d_wdata -> d_addr_ok : data request
//   d_data_ok/d_rdata                : data response pulse, full beat
//   m_valid/m_is_write/m_addr/m_size/m_strobe/m_wdata, m_ready : downstream req
//   m_resp_valid/m_resp_data         : downstream response beat
// ADDR_W/DATA_W must match the package widths used by arb_req_t.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int INSTR_W = ARB_INSTR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [INSTR_W-1:0]  i_data,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_valid,
  output logic                m_is_write,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ready,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_resp_data
);

  arb_state_t state;
  arb_state_t next_state;
  arb_port_t  last_grant;
  arb_port_t  pick;
  logic       any;
  logic       grant_fire;
  arb_req_t   req;
  arb_req_t   new_req;

  arb_rr_pick u_pick (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (any)
  );

  // Fetches are always a 4-byte read, so size/strobe/wdata are fixed.
  always_comb begin
    new_req = '0;
    if (pick == IBUS) begin
      new_req.addr = i_addr;
      new_req.size = MSIZE4;
    end else begin
      new_req.addr   = d_addr;
      new_req.size   = d_size;
      new_req.strobe = d_strobe;
      new_req.wdata  = d_wdata;
    end
  end

  // last_grant doubles as the owner of the in-flight transaction, since it
  // only changes on grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= DBUS;
      req        <= '0;
    end else begin
      state <= next_state;
      if (grant_fire) begin
        last_grant <= pick;
        req        <= new_req;
      end
    end
  end

  // Handshake outputs are combinational; all of them are forced low while
  // reset is asserted so an in-flight response is silently dropped.
  always_comb begin
    next_state = state;
    grant_fire = 1'b0;
    m_valid    = 1'b0;
    i_addr_ok  = 1'b0;
    d_addr_ok  = 1'b0;
    i_data_ok  = 1'b0;
    d_data_ok  = 1'b0;
    i_data     = '0;
    d_rdata    = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (any) begin
            grant_fire = 1'b1;
            next_state = REQ;
            if (pick == IBUS) begin
              i_addr_ok = 1'b1;
            end else begin
              d_addr_ok = 1'b1;
            end
          end
        end
        REQ: begin
          m_valid = 1'b1;
          if (m_ready) begin
            next_state = WAIT;
          end
        end
        WAIT: begin
          if (m_resp_valid) begin
            next_state = IDLE;
            if (last_grant == IBUS) begin
              i_data_ok = 1'b1;
              i_data    = req.addr[2] ? m_resp_data[2*INSTR_W-1:INSTR_W]
                                      : m_resp_data[INSTR_W-1:0];
            end else begin
              d_data_ok = 1'b1;
              d_rdata   = m_resp_data;
            end
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  assign m_addr     = req.addr;
  assign m_size     = req.size;
  assign m_strobe   = req.strobe;
  assign m_wdata    = req.wdata;
  assign m_is_write = |req.strobe;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of single-port transactions,
// hand-written contention and reset-in-WAIT sequences, and a randomized run
// checked against a transaction-level round-robin model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [63:0] d_rdata;
  logic        m_valid;
  logic        m_is_write;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_ready;
  logic        m_resp_valid;
  logic [63:0] m_resp_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_addr       (i_addr),
    .i_addr_ok    (i_addr_ok),
    .i_data_ok    (i_data_ok),
    .i_data       (i_data),
    .d_valid      (d_valid),
    .d_addr       (d_addr),
    .d_size       (d_size),
    .d_strobe     (d_strobe),
    .d_wdata      (d_wdata),
    .d_addr_ok    (d_addr_ok),
    .d_data_ok    (d_data_ok),
    .d_rdata      (d_rdata),
    .m_valid      (m_valid),
    .m_is_write   (m_is_write),
    .m_addr       (m_addr),
    .m_size       (m_size),
    .m_strobe     (m_strobe),
    .m_wdata      (m_wdata),
    .m_ready      (m_ready),
    .m_resp_valid (m_resp_valid),
    .m_resp_data  (m_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The downstream model must never accept and respond in the same cycle.
  always @(negedge clk) begin
    if (m_valid && m_ready && m_resp_valid) begin
      errors++;
      $display("[TB] FAIL downstream_protocol: m_ready and m_resp_valid both high in REQ");
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  typedef struct {
    logic        is_d;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] beat;
    int          ready_delay;
    int          resp_delay;
    logic [2:0]  exp_size;
    logic [7:0]  exp_strobe;
    logic [63:0] exp_wdata;
    logic [63:0] exp_data;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [63:0] ia,
                               input logic dv, input logic [63:0] da,
                               input logic [2:0] ds, input logic [7:0] dst,
                               input logic [63:0] dw);
    i_valid  = iv;
    i_addr   = ia;
    d_valid  = dv;
    d_addr   = da;
    d_size   = ds;
    d_strobe = dst;
    d_wdata  = dw;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "_addr_ok"}, 64'({d_addr_ok, i_addr_ok}), 64'd0);
    checkOutput({tag, "_data_ok"}, 64'({d_data_ok, i_data_ok}), 64'd0);
    checkOutput({tag, "_i_data"}, 64'(i_data), 64'd0);
    checkOutput({tag, "_d_rdata"}, d_rdata, 64'd0);
    checkOutput({tag, "_m_addr"}, m_addr, 64'd0);
    checkOutput({tag, "_m_size"}, 64'(m_size), 64'd0);
    checkOutput({tag, "_m_strobe"}, 64'(m_strobe), 64'd0);
    checkOutput({tag, "_m_wdata"}, m_wdata, 64'd0);
    checkOutput({tag, "_m_is_write"}, 64'(m_is_write), 64'd0);
  endtask

  task automatic doReset();
    reset        = 1'b1;
    m_ready      = 1'b0;
    m_resp_valid = 1'b0;
    m_resp_data  = '0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs one full transaction starting just after a clock edge with the
  // arbiter idle and request inputs already driven. exp_port: 0=ibus, 1=dbus.
  task automatic runTxn(input int exp_port, input logic [63:0] exp_addr,
                        input logic [2:0] exp_size, input logic [7:0] exp_strobe,
                        input logic [63:0] exp_wdata, input int ready_delay,
                        input int resp_delay, input logic [63:0] beat,
                        input logic [63:0] exp_data);
    logic [1:0] exp_onehot;
    exp_onehot = (exp_port == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    checkOutput("grant_addr_ok", 64'({d_addr_ok, i_addr_ok}), 64'(exp_onehot));
    checkOutput("grant_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    m_ready = (ready_delay == 0);
    for (int c = 0; c <= ready_delay; c++) begin
      @(negedge clk);
      checkOutput("req_m_valid", 64'(m_valid), 64'd1);
      checkOutput("req_m_addr", m_addr, exp_addr);
      checkOutput("req_m_size", 64'(m_size), 64'(exp_size));
      checkOutput("req_m_strobe", 64'(m_strobe), 64'(exp_strobe));
      checkOutput("req_m_wdata", m_wdata, exp_wdata);
      checkOutput("req_m_is_write", 64'(m_is_write), 64'(exp_strobe != 8'd0));
      checkOutput("req_no_addr_ok", 64'({d_addr_ok, i_addr_ok}), 64'd0);
      checkOutput("req_no_data_ok", 64'({d_data_ok, i_data_ok}), 64'd0);
      @(posedge clk);
      #1;
      m_ready = (c + 1 == ready_delay);
    end
    for (int c = 0; c < resp_delay; c++) begin
      @(negedge clk);
      checkOutput("wait_m_valid", 64'(m_valid), 64'd0);
      checkOutput("wait_no_data_ok", 64'({d_data_ok, i_data_ok}), 64'd0);
      @(posedge clk);
      #1;
    end
    m_resp_valid = 1'b1;
    m_resp_data  = beat;
    @(negedge clk);
    checkOutput("resp_m_valid", 64'(m_valid), 64'd0);
    checkOutput("resp_data_ok", 64'({d_data_ok, i_data_ok}), 64'(exp_onehot));
    if (exp_port == 0) begin
      checkOutput("resp_i_data", 64'(i_data), {32'd0, exp_data[31:0]});
    end else begin
      checkOutput("resp_d_rdata", d_rdata, exp_data);
    end
    @(posedge clk);
    #1;
    m_resp_valid = 1'b0;
    m_resp_data  = '0;
  endtask

  // Reference rule for the word a fetch sees out of a 64-bit beat.
  function automatic logic [63:0] fetchWord(input logic [63:0] addr,
                                            input logic [63:0] beat);
    logic [63:0] shifted;
    shifted = addr[2] ? (beat >> 32) : beat;
    return shifted & 64'h0000_0000_FFFF_FFFF;
  endfunction

  initial begin
    vec_t        vecs[5];
    logic [63:0] beat;
    int          model_last;
    int          exp_port;
    logic        i_pend;
    logic        d_pend;
    logic [63:0] ra_i;
    logic [63:0] ra_d;
    logic [2:0]  rs_d;
    logic [7:0]  rst_d;
    logic [63:0] rw_d;

    vecs[0] = '{1'b0, 64'h8000_0004, 3'd0, 8'h00, 64'd0, 64'h1122_3344_5566_7788,
                0, 0, MSIZE4, 8'h00, 64'd0, 64'h1122_3344};
    vecs[1] = '{1'b0, 64'h8000_0000, 3'd0, 8'h00, 64'd0, 64'h1122_3344_5566_7788,
                0, 1, MSIZE4, 8'h00, 64'd0, 64'h5566_7788};
    vecs[2] = '{1'b1, 64'h8000_1000, MSIZE8, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D,
                64'h0123_4567_89AB_CDEF, 0, 0, MSIZE8, 8'hFF,
                64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{1'b1, 64'h8000_2008, MSIZE4, 8'h00, 64'h5555_AAAA_5555_AAAA,
                64'hA5A5_5A5A_0F0F_F0F0, 5, 0, MSIZE4, 8'h00,
                64'h5555_AAAA_5555_AAAA, 64'hA5A5_5A5A_0F0F_F0F0};
    vecs[4] = '{1'b1, 64'h8000_3003, MSIZE1, 8'h08, 64'h0000_0000_7700_0000,
                64'hFFFF_0000_FFFF_0000, 2, 2, MSIZE1, 8'h08,
                64'h0000_0000_7700_0000, 64'hFFFF_0000_FFFF_0000};

    // Reset with both ports requesting: no grant may leak out.
    reset        = 1'b1;
    m_ready      = 1'b0;
    m_resp_valid = 1'b0;
    m_resp_data  = '0;
    applyStimulus(1'b1, 64'h8000_0000, 1'b1, 64'h8000_1000, MSIZE8, 8'hFF, 64'h1);
    @(negedge clk);
    checkOutput("reset_addr_ok_gated", 64'({d_addr_ok, i_addr_ok}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkAllZero("reset_hold");
    doReset();
    @(negedge clk);
    checkAllZero("after_reset");
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].is_d) begin
        applyStimulus(1'b0, '0, 1'b1, vecs[v].addr, vecs[v].size, vecs[v].strobe,
                      vecs[v].wdata);
      end else begin
        applyStimulus(1'b1, vecs[v].addr, 1'b0, '0, '0, '0, '0);
      end
      runTxn(vecs[v].is_d ? 1 : 0, vecs[v].addr, vecs[v].exp_size,
             vecs[v].exp_strobe, vecs[v].exp_wdata, vecs[v].ready_delay,
             vecs[v].resp_delay, vecs[v].beat, vecs[v].exp_data);
      applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, '0);
    end

    $display("[TB] contention from reset");
    doReset();
    applyStimulus(1'b1, 64'h8000_0104, 1'b1, 64'h8000_2000, MSIZE8, 8'h00, 64'd0);
    for (int t = 0; t < 4; t++) begin
      beat = {$urandom, $urandom};
      if (t % 2 == 0) begin
        runTxn(0, 64'h8000_0104, MSIZE4, 8'h00, 64'd0, 0, 0, beat,
               fetchWord(64'h8000_0104, beat));
      end else begin
        runTxn(1, 64'h8000_2000, MSIZE8, 8'h00, 64'd0, 0, 0, beat, beat);
      end
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, '0);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, '0, 1'b1, 64'h8000_4000, MSIZE8, 8'hFF, 64'h1234);
    @(negedge clk);
    checkOutput("rw_grant", 64'({d_addr_ok, i_addr_ok}), 64'd2);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready      = 1'b0;
    reset        = 1'b1;
    m_resp_valid = 1'b1;
    m_resp_data  = 64'hCAFE_CAFE_CAFE_CAFE;
    @(negedge clk);
    checkOutput("rw_no_data_ok_in_reset", 64'({d_data_ok, i_data_ok}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    checkAllZero("rw_after");
    @(posedge clk);
    #1;
    m_resp_valid = 1'b0;
    m_resp_data  = '0;
    // last_grant is back to DBUS after reset, so ibus wins the tie.
    applyStimulus(1'b1, 64'h8000_0008, 1'b1, 64'h8000_4000, MSIZE8, 8'hFF, 64'h1234);
    beat = 64'h89AB_CDEF_0123_4567;
    runTxn(0, 64'h8000_0008, MSIZE4, 8'h00, 64'd0, 0, 0, beat, 64'h0123_4567);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, '0);

    $display("[TB] randomized run");
    doReset();
    model_last = 1;
    i_pend     = 1'b0;
    d_pend     = 1'b0;
    ra_i       = '0;
    ra_d       = '0;
    rs_d       = '0;
    rst_d      = '0;
    rw_d       = '0;
    for (int it = 0; it < 200; it++) begin
      if (!i_pend && ($urandom_range(1, 0) == 1)) begin
        i_pend = 1'b1;
        ra_i   = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
      end
      if (!d_pend && ($urandom_range(1, 0) == 1)) begin
        d_pend = 1'b1;
        ra_d   = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFF8;
        rs_d   = 3'($urandom_range(3, 0));
        rst_d  = ($urandom_range(1, 0) == 1) ? 8'($urandom) : 8'h00;
        rw_d   = {$urandom, $urandom};
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1'b1;
        ra_i   = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
      end
      applyStimulus(i_pend, i_pend ? ra_i : 64'd0, d_pend, d_pend ? ra_d : 64'd0,
                    d_pend ? rs_d : 3'd0, d_pend ? rst_d : 8'd0,
                    d_pend ? rw_d : 64'd0);
      if (i_pend && d_pend) begin
        exp_port = (model_last == 1) ? 0 : 1;
      end else begin
        exp_port = i_pend ? 0 : 1;
      end
      model_last = exp_port;
      beat = {$urandom, $urandom};
      if (exp_port == 0) begin
        runTxn(0, ra_i, MSIZE4, 8'h00, 64'd0, $urandom_range(3, 0),
               $urandom_range(2, 0), beat, fetchWord(ra_i, beat));
        i_pend = 1'b0;
      end else begin
        runTxn(1, ra_d, rs_d, rst_d, rw_d, $urandom_range(3, 0),
               $urandom_range(2, 0), beat, beat);
        d_pend = 1'b0;
      end
      applyStimulus(i_pend, i_pend ? ra_i : 64'd0, d_pend, d_pend ? ra_d : 64'd0,
                    d_pend ? rs_d : 3'd0, d_pend ? rst_d : 8'd0,
                    d_pend ? rw_d : 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
